// File: rtl/mem_stream_pkg.sv
// Shared state encoding and default widths for the RAM stream reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_STREAM = 2'd1;
    localparam state_t S_DONE   = 2'd2;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register holding data plus an end-of-burst flag.
// Latency: a load appears on the outputs one clock later.
// Backpressure: contents hold while out_valid & !out_ready; accept without load empties it.
module stream_out_reg
    import mem_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              empty,
    output logic              accept,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    assign empty     = ~valid_q;
    assign accept    = valid_q & out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

    // Next contents: clear wins over load, load wins over draining on accept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (clear) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            last_d  = load_last;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Register state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Walks a combinational RAM read port from base_addr for len words, emitting a valid/ready stream.
// Latency: start sampled at edge E0, first out_valid after E0+2, then one word per clock.
// Backpressure: stall holds data/last/pointer/count; abort in STREAM cancels with no done pulse.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Largest burst the RAM can supply: its full depth.
    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              primed_q, primed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic reg_load, reg_clear, reg_empty, reg_accept;

    assign ram_addr = rd_ptr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    stream_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (reg_load),
        .clear     (reg_clear),
        .load_data (ram_q),
        .load_last (rem_q == ONE_L),
        .empty     (reg_empty),
        .accept    (reg_accept),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Burst sequencing: the first STREAM cycle only presents the freshly latched
    // address, so every capture sees an address that has been stable a full cycle.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        primed_d  = primed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        reg_load  = 1'b0;
        reg_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_ptr_d = base_addr;
                        rem_d    = (len > MAX_LEN) ? MAX_LEN : len;
                        primed_d = 1'b0;
                        state_d  = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (abort) begin
                    reg_clear = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (!primed_q) begin
                    primed_d = 1'b1;
                end else if (rem_q != '0) begin
                    if (reg_empty || reg_accept) begin
                        reg_load = 1'b1;
                        rd_ptr_d = rd_ptr_q + ONE_A;
                        rem_d    = rem_q - ONE_L;
                    end
                end else if (reg_accept) begin
                    reg_clear = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            rem_q    <= '0;
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            primed_q <= primed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule
